// File: rtl/time_uart_reporter_pkg.sv
// time_uart_reporter_pkg
// Shared constants for the serial time reporter: ASCII codes used in the
// "HH:MM:SS.CC\r\n" line, the layout of the packed 24-bit time bus, the
// character-index encoding of the line and the transmitter FSM encoding.
package time_uart_reporter_pkg;

    // ASCII codes
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Packed time bus layout: hour [23:19], min [18:13], sec [12:7], cs [6:0]
    localparam int TIME_W    = 24;
    localparam int HOUR_LSB  = 19;
    localparam int HOUR_W    = 5;
    localparam int MIN_LSB   = 13;
    localparam int MIN_W     = 6;
    localparam int SEC_LSB   = 7;
    localparam int SEC_W     = 6;
    localparam int MSEC_LSB  = 0;
    localparam int MSEC_W    = 7;

    // Largest legal value of each field; larger values are clamped
    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MSEC_MAX = 7'd99;

    // Line layout, character index 0..12
    localparam int         LINE_LEN     = 13;
    localparam int         CHAR_IDX_W   = 4;
    localparam logic [3:0] CHAR_HOUR_T  = 4'd0;
    localparam logic [3:0] CHAR_HOUR_O  = 4'd1;
    localparam logic [3:0] CHAR_COLON_A = 4'd2;
    localparam logic [3:0] CHAR_MIN_T   = 4'd3;
    localparam logic [3:0] CHAR_MIN_O   = 4'd4;
    localparam logic [3:0] CHAR_COLON_B = 4'd5;
    localparam logic [3:0] CHAR_SEC_T   = 4'd6;
    localparam logic [3:0] CHAR_SEC_O   = 4'd7;
    localparam logic [3:0] CHAR_DOT     = 4'd8;
    localparam logic [3:0] CHAR_MSEC_T  = 4'd9;
    localparam logic [3:0] CHAR_MSEC_O  = 4'd10;
    localparam logic [3:0] CHAR_CR      = 4'd11;
    localparam logic [3:0] CHAR_LF      = 4'd12;
    localparam logic [3:0] CHAR_LAST    = CHAR_IDX_W'(LINE_LEN - 1);

    // Transmitter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/time_uart_reporter_bin2ascii_2digit.sv
// bin2ascii_2digit
// Clamps a 7-bit field to a maximum, then splits it into tens and ones
// ASCII digits. Purely combinational; the tens digit comes from a chain of
// compares against multiples of ten so no divider is needed.
//   value      : field value (0..127)
//   clamp_max  : largest value passed through (must be <= 99)
//   tens_ascii : '0' + value / 10
//   ones_ascii : '0' + value % 10
module bin2ascii_2digit
    import time_uart_reporter_pkg::*;
(
    input  logic [6:0] value,
    input  logic [6:0] clamp_max,
    output logic [7:0] tens_ascii,
    output logic [7:0] ones_ascii
);

    logic [6:0] clamped;
    logic [3:0] tens;
    logic [6:0] rem;

    always_comb begin
        clamped = (value > clamp_max) ? clamp_max : value;
        tens    = 4'd0;
        // Highest multiple of ten not above the value wins
        for (int i = 1; i <= 9; i++) begin
            if (clamped >= 7'(i * 10)) begin
                tens = 4'(i);
            end
        end
        rem        = clamped - (7'({3'b000, tens}) * 7'd10);
        tens_ascii = ASCII_ZERO + {4'b0000, tens};
        ones_ascii = ASCII_ZERO + {1'b0, rem};
    end

endmodule

// File: rtl/time_uart_reporter.sv
// time_uart_reporter
// Snapshots the packed time bus on a send request and transmits it as the
// 13-character line "HH:MM:SS.CC\r\n" over a UART 8N1 link.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   i_time  : packed time (hour [23:19], min [18:13], sec [12:7], cs [6:0])
//   i_send  : single-cycle request, ignored while busy
//   o_tx    : UART line, idle high, registered
//   o_busy  : high while a line is being transmitted
//   o_done  : one-cycle pulse when the last stop bit ends
module time_uart_reporter
    import time_uart_reporter_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] i_time,
    input  logic              i_send,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [CHAR_IDX_W-1:0] char_idx_q, char_idx_d;
    logic [TIME_W-1:0]     snap_q, snap_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o, msec_t, msec_o;
    logic [7:0] cur_char;

    bin2ascii_2digit u_hour (
        .value      ({2'b00, snap_q[HOUR_LSB +: HOUR_W]}),
        .clamp_max  (HOUR_MAX),
        .tens_ascii (hour_t),
        .ones_ascii (hour_o)
    );

    bin2ascii_2digit u_min (
        .value      ({1'b0, snap_q[MIN_LSB +: MIN_W]}),
        .clamp_max  (MIN_MAX),
        .tens_ascii (min_t),
        .ones_ascii (min_o)
    );

    bin2ascii_2digit u_sec (
        .value      ({1'b0, snap_q[SEC_LSB +: SEC_W]}),
        .clamp_max  (SEC_MAX),
        .tens_ascii (sec_t),
        .ones_ascii (sec_o)
    );

    bin2ascii_2digit u_msec (
        .value      (snap_q[MSEC_LSB +: MSEC_W]),
        .clamp_max  (MSEC_MAX),
        .tens_ascii (msec_t),
        .ones_ascii (msec_o)
    );

    always_comb begin
        case (char_idx_q)
            CHAR_HOUR_T:  cur_char = hour_t;
            CHAR_HOUR_O:  cur_char = hour_o;
            CHAR_COLON_A: cur_char = ASCII_COLON;
            CHAR_MIN_T:   cur_char = min_t;
            CHAR_MIN_O:   cur_char = min_o;
            CHAR_COLON_B: cur_char = ASCII_COLON;
            CHAR_SEC_T:   cur_char = sec_t;
            CHAR_SEC_O:   cur_char = sec_o;
            CHAR_DOT:     cur_char = ASCII_DOT;
            CHAR_MSEC_T:  cur_char = msec_t;
            CHAR_MSEC_O:  cur_char = msec_o;
            CHAR_CR:      cur_char = ASCII_CR;
            default:      cur_char = ASCII_LF;
        endcase
    end

    // The character byte is picked up when the start bit ends, by which time
    // the snapshot is settled; the line value is computed one bit ahead.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        snap_d     = snap_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_send) begin
                    state_d    = ST_START;
                    snap_d     = i_time;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_cnt_d = '0;
                    char_idx_d = '0;
                end
            end
            ST_START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = cur_char[0];
                    shift_d    = {1'b0, cur_char[7:1]};
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                // Stop bit: chain straight into the next start bit, or finish
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (char_idx_q == CHAR_LAST) begin
                        state_d    = ST_IDLE;
                        char_idx_d = '0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = ST_START;
                        char_idx_d = char_idx_q + 1'b1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= '0;
            snap_q     <= '0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            snap_q     <= snap_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_time_uart_reporter.sv
// tb_time_uart_reporter
// Directed bench for time_uart_reporter at BAUD_DIV = 4 (one line = 520
// clocks). Each line is decoded by sampling o_tx in the middle of every bit
// and compared against the expected text written out by hand.
module tb_time_uart_reporter;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 250_000;
    localparam int BD       = CLK_FREQ / BAUD;

    logic        clk;
    logic        reset;
    logic [23:0] i_time;
    logic        i_send;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int tests_run;
    int tests_failed;

    time_uart_reporter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_time (i_time),
        .i_send (i_send),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pack_time(input int h, input int m, input int s, input int c);
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    // Byte k of the expected line: the 11 visible characters then CR, LF
    function automatic logic [7:0] exp_byte(input string s, input int k);
        if (k < 11) return s[k];
        else if (k == 11) return 8'h0D;
        else return 8'h0A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents i_time and pulses i_send into edge N; returns at N + 1ns
    task automatic applyStimulus(input logic [23:0] t);
        @(negedge clk);
        i_time = t;
        i_send = 1'b1;
        @(posedge clk);
        #1;
        i_send = 1'b0;
        checkOutput("accept_busy", 32'(o_busy), 32'd1);
        checkOutput("accept_tx", 32'(o_tx), 32'd0);
    endtask

    // Entered at N + 1ns after the accept edge. Decodes 13 characters, then
    // checks the o_busy/o_done handoff. With chain set, i_send is raised in
    // the o_done cycle and the task returns 1ns after the new accept edge.
    task automatic receiveLine(input string name, input string exp_str, input bit chain);
        logic [7:0] rx;
        logic       start_bit;
        logic       stop_bit;
        logic       busy_seen;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 13; k++) begin
            #1;
            start_bit = o_tx;
            busy_seen = o_busy;
            for (int b = 0; b < 8; b++) begin
                repeat (BD) @(posedge clk);
                #1;
                rx[b] = o_tx;
            end
            repeat (BD) @(posedge clk);
            #1;
            stop_bit = o_tx;
            checkOutput($sformatf("%s_start%0d", name, k), 32'(start_bit), 32'd0);
            checkOutput($sformatf("%s_busy%0d", name, k), 32'(busy_seen), 32'd1);
            checkOutput($sformatf("%s_char%0d", name, k), 32'(rx), 32'(exp_byte(exp_str, k)));
            checkOutput($sformatf("%s_stop%0d", name, k), 32'(stop_bit), 32'd1);
            if (k < 12) repeat (BD) @(posedge clk);
        end
        // Last stop-bit sample was 2 clocks into the final bit
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s_busy_519", name), 32'(o_busy), 32'd1);
        checkOutput($sformatf("%s_done_519", name), 32'(o_done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s_busy_520", name), 32'(o_busy), 32'd0);
        checkOutput($sformatf("%s_done_520", name), 32'(o_done), 32'd1);
        checkOutput($sformatf("%s_tx_520", name), 32'(o_tx), 32'd1);
        if (chain) i_send = 1'b1;
        @(posedge clk);
        #1;
        if (chain) i_send = 1'b0;
        checkOutput($sformatf("%s_done_521", name), 32'(o_done), 32'd0);
        checkOutput($sformatf("%s_busy_521", name), 32'(o_busy), chain ? 32'd1 : 32'd0);
        checkOutput($sformatf("%s_tx_521", name), 32'(o_tx), chain ? 32'd0 : 32'd1);
    endtask

    // Watches the line for n clocks and reports whether it ever left idle
    task automatic watchIdle(input string name, input int n);
        logic activity;
        activity = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (o_busy !== 1'b0 || o_tx !== 1'b1 || o_done !== 1'b0) activity = 1'b1;
        end
        checkOutput(name, 32'(activity), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        i_time       = 24'h000000;
        i_send       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", 32'(o_tx), 32'd1);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        watchIdle("idle_after_reset", 8);

        // Basic line
        applyStimulus(pack_time(12, 34, 56, 78));
        receiveLine("basic", "12:34:56.78", 1'b0);

        // All-zero and all-maximum legal values
        applyStimulus(pack_time(0, 0, 0, 0));
        receiveLine("zero", "00:00:00.00", 1'b0);
        applyStimulus(pack_time(23, 59, 59, 99));
        receiveLine("max", "23:59:59.99", 1'b0);

        // Out-of-range fields clamp
        applyStimulus(pack_time(31, 63, 60, 127));
        receiveLine("clamp", "23:59:59.99", 1'b0);

        // Snapshot holds while i_time churns; requests while busy are dropped
        applyStimulus(pack_time(1, 2, 3, 4));
        fork
            receiveLine("snap", "01:02:03.04", 1'b0);
            begin
                for (int c = 1; c < 519; c++) begin
                    @(negedge clk);
                    i_time = 24'($urandom);
                    i_send = (c == 10 || c == 300);
                end
                @(negedge clk);
                i_send = 1'b0;
            end
        join
        watchIdle("no_queued_line", 60);

        // Reset in the middle of a line (clock 200: start bit of char 5)
        applyStimulus(pack_time(9, 8, 7, 6));
        repeat (200) @(posedge clk);
        #1;
        checkOutput("pre_reset_tx", 32'(o_tx), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_tx", 32'(o_tx), 32'd1);
        checkOutput("async_reset_busy", 32'(o_busy), 32'd0);
        checkOutput("async_reset_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        watchIdle("idle_after_mid_reset", 60);
        applyStimulus(pack_time(10, 20, 30, 40));
        receiveLine("post_reset", "10:20:30.40", 1'b0);

        // Request in the o_done cycle chains straight into a second line
        applyStimulus(pack_time(5, 6, 7, 8));
        receiveLine("chain_a", "05:06:07.08", 1'b1);
        receiveLine("chain_b", "05:06:07.08", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
